// File: rtl/dma_sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_sync_fifo_pkg
//  Description : Shared sizing defaults and types for the SD host DMA FIFO.
//                The DMA engine and the data-line serializer import this
//                package so both sides size their FIFO interface identically.
//  Revision    : 1.0 - initial release
// ============================================================================
package dma_sync_fifo_pkg;

    // Default geometry: 16 words of 32 bits.
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 4;

    // Default watermark thresholds, in words.
    localparam int DEF_AFULL_LEVEL  = 14;
    localparam int DEF_AEMPTY_LEVEL = 2;

    // Per-cycle level operation, encoded as {read accepted, write accepted}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_BOTH = 2'b11
    } level_op_e;

endpackage : dma_sync_fifo_pkg
`default_nettype wire

// File: rtl/dma_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dma_fifo_ram
//  Description : Simple dual-port RAM, DEPTH x DATA_WIDTH, synchronous write
//                and synchronous read, no reset (block-RAM inferable).
//                The read register only loads when re_i is high, so the
//                output holds the last word read.
//  Ports       : clk_i    - clock
//                we_i     - write enable
//                waddr_i  - write address
//                wdata_i  - write data
//                re_i     - read enable
//                raddr_i  - read address
//                rdata_o  - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : dma_fifo_ram
`default_nettype wire

// File: rtl/dma_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dma_sync_fifo
//  Description : Single-clock circular-buffer FIFO between the SD host DMA
//                engine and the data-line serializer. Holds read/write
//                pointers, a fill-level counter, watermark flags decoded from
//                the registered level, sticky overflow/underflow flags, a
//                one-cycle write acknowledge and a read-valid strobe.
//  Ports       : Clk, Reset (sync, active-high), Flush_in (sync clear)
//                Data_in/WriteEn_in -> ack_write, Full_out, AlmostFull_out
//                ReadEn_in -> Data_out, Valid_out, Empty_out, AlmostEmpty_out
//                Level_out (0..DEPTH), Overflow_out, Underflow_out (sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_sync_fifo
    import dma_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int AFULL_LEVEL  = DEF_AFULL_LEVEL,
    parameter int AEMPTY_LEVEL = DEF_AEMPTY_LEVEL
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Flush_in,
    input  logic [DATA_WIDTH-1:0] Data_in,
    input  logic                  WriteEn_in,
    output logic                  ack_write,
    output logic                  Full_out,
    output logic                  AlmostFull_out,
    input  logic                  ReadEn_in,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Valid_out,
    output logic                  Empty_out,
    output logic                  AlmostEmpty_out,
    output logic [ADDR_WIDTH:0]   Level_out,
    output logic                  Overflow_out,
    output logic                  Underflow_out
);

    localparam int LVL_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  ack_q, ack_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    // Masks the un-reset RAM output register until the first read after reset.
    logic                  dzero_q, dzero_d;

    logic                  full_w, empty_w;
    logic                  wr_acc_w, rd_acc_w;
    level_op_e             op_w;
    logic [DATA_WIDTH-1:0] ram_rdata_w;

    // Flags come from the registered level only.
    assign full_w  = (level_q == LVL_W'(DEPTH));
    assign empty_w = (level_q == '0);

    // Reset is included so the RAM and read register stay idle during reset.
    assign wr_acc_w = WriteEn_in && !full_w  && !Flush_in && !Reset;
    assign rd_acc_w = ReadEn_in  && !empty_w && !Flush_in && !Reset;
    assign op_w     = level_op_e'({rd_acc_w, wr_acc_w});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ack_d    = wr_acc_w;
        valid_d  = rd_acc_w;
        ovf_d    = ovf_q | (WriteEn_in && full_w);
        unf_d    = unf_q | (ReadEn_in && empty_w);
        dzero_d  = dzero_q && !rd_acc_w;

        if (wr_acc_w) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc_w) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        case (op_w)
            OP_WR:   level_d = level_q + LVL_W'(1);
            OP_RD:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Flush clears state but leaves the read data register alone.
        if (Flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ack_d    = 1'b0;
            valid_d  = 1'b0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            dzero_d  = dzero_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ack_q    <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dzero_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ack_q    <= ack_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dzero_q  <= dzero_d;
        end
    end

    dma_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (Clk),
        .we_i    (wr_acc_w),
        .waddr_i (wr_ptr_q),
        .wdata_i (Data_in),
        .re_i    (rd_acc_w),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata_w)
    );

    assign Data_out        = dzero_q ? '0 : ram_rdata_w;
    assign Valid_out       = valid_q;
    assign ack_write       = ack_q;
    assign Full_out        = full_w;
    assign Empty_out       = empty_w;
    assign AlmostFull_out  = (level_q >= LVL_W'(AFULL_LEVEL));
    assign AlmostEmpty_out = (level_q <= LVL_W'(AEMPTY_LEVEL));
    assign Level_out       = level_q;
    assign Overflow_out    = ovf_q;
    assign Underflow_out   = unf_q;

endmodule : dma_sync_fifo
`default_nettype wire

// File: tb/tb_dma_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_sync_fifo
//  Description : Directed self-checking bench for dma_sync_fifo (16 x 32).
//                Inputs change 1 ns after a rising edge; outputs are sampled
//                at that same point, i.e. they reflect the edge just taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_sync_fifo;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Flush_in = 1'b0;
    logic [31:0] Data_in = '0;
    logic        WriteEn_in = 1'b0;
    logic        ReadEn_in = 1'b0;
    logic        ack_write, Full_out, AlmostFull_out;
    logic [31:0] Data_out;
    logic        Valid_out, Empty_out, AlmostEmpty_out;
    logic [4:0]  Level_out;
    logic        Overflow_out, Underflow_out;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    dma_sync_fifo #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (4),
        .AFULL_LEVEL  (14),
        .AEMPTY_LEVEL (2)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Flush_in        (Flush_in),
        .Data_in         (Data_in),
        .WriteEn_in      (WriteEn_in),
        .ack_write       (ack_write),
        .Full_out        (Full_out),
        .AlmostFull_out  (AlmostFull_out),
        .ReadEn_in       (ReadEn_in),
        .Data_out        (Data_out),
        .Valid_out       (Valid_out),
        .Empty_out       (Empty_out),
        .AlmostEmpty_out (AlmostEmpty_out),
        .Level_out       (Level_out),
        .Overflow_out    (Overflow_out),
        .Underflow_out   (Underflow_out)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Packed view of all single-bit status outputs:
    // {ack, valid, full, afull, empty, aempty, ovf, unf}
    function automatic logic [7:0] status();
        return {ack_write, Valid_out, Full_out, AlmostFull_out,
                Empty_out, AlmostEmpty_out, Overflow_out, Underflow_out};
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        total++;
        if (status() !== 8'b0000_1100) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=%b", status(), 8'b0000_1100);
        end
        total++;
        if (Level_out !== 5'd0) begin
            bad++;
            $display("FAIL reset_level got=%0d exp=0", Level_out);
        end
        total++;
        if (Data_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=00000000", Data_out);
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic fill16(input logic [31:0] base, input bit check);
        for (int i = 1; i <= 16; i++) begin
            WriteEn_in = 1'b1;
            Data_in    = base + 32'(i);
            tick();
            if (check) begin
                total++;
                if (ack_write !== 1'b1 || Level_out !== 5'(i)) begin
                    bad++;
                    $display("FAIL fill_ack_level i=%0d ack=%b lvl=%0d exp ack=1 lvl=%0d",
                             i, ack_write, Level_out, i);
                end
                total++;
                if (Full_out !== (i == 16) || AlmostFull_out !== (i >= 14) ||
                    Empty_out !== 1'b0 || AlmostEmpty_out !== (i <= 2)) begin
                    bad++;
                    $display("FAIL fill_flags i=%0d full=%b afull=%b empty=%b aempty=%b exp %b %b 0 %b",
                             i, Full_out, AlmostFull_out, Empty_out, AlmostEmpty_out,
                             (i == 16), (i >= 14), (i <= 2));
                end
            end
        end
        WriteEn_in = 1'b0;
    endtask

    task automatic test_fill();
        fill16(32'h0, 1'b1);
    endtask

    task automatic test_overflow();
        WriteEn_in = 1'b1;
        Data_in    = 32'h99;
        tick();
        WriteEn_in = 1'b0;
        total++;
        if (ack_write !== 1'b0 || Overflow_out !== 1'b1 || Level_out !== 5'd16) begin
            bad++;
            $display("FAIL overflow ack=%b ovf=%b lvl=%0d exp ack=0 ovf=1 lvl=16",
                     ack_write, Overflow_out, Level_out);
        end
        tick();
        total++;
        if (Overflow_out !== 1'b1) begin
            bad++;
            $display("FAIL overflow_sticky got=%b exp=1", Overflow_out);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            ReadEn_in = 1'b1;
            tick();
            total++;
            if (Valid_out !== 1'b1 || Data_out !== 32'(i) || Level_out !== 5'(16 - i)) begin
                bad++;
                $display("FAIL drain i=%0d valid=%b data=%h lvl=%0d exp valid=1 data=%h lvl=%0d",
                         i, Valid_out, Data_out, Level_out, 32'(i), 16 - i);
            end
        end
        ReadEn_in = 1'b0;
        tick();
        total++;
        if (Valid_out !== 1'b0 || Data_out !== 32'h10 || Empty_out !== 1'b1) begin
            bad++;
            $display("FAIL drain_hold valid=%b data=%h empty=%b exp valid=0 data=00000010 empty=1",
                     Valid_out, Data_out, Empty_out);
        end
    endtask

    task automatic test_underflow_flush();
        ReadEn_in = 1'b1;
        tick();
        ReadEn_in = 1'b0;
        total++;
        if (Valid_out !== 1'b0 || Underflow_out !== 1'b1 || Level_out !== 5'd0) begin
            bad++;
            $display("FAIL underflow valid=%b unf=%b lvl=%0d exp valid=0 unf=1 lvl=0",
                     Valid_out, Underflow_out, Level_out);
        end
        Flush_in = 1'b1;
        tick();
        Flush_in = 1'b0;
        total++;
        if (Overflow_out !== 1'b0 || Underflow_out !== 1'b0 || Level_out !== 5'd0 ||
            Data_out !== 32'h10) begin
            bad++;
            $display("FAIL flush_clear ovf=%b unf=%b lvl=%0d data=%h exp 0 0 0 00000010",
                     Overflow_out, Underflow_out, Level_out, Data_out);
        end
    endtask

    task automatic test_wrap();
        int exp_next = 0;
        for (int i = 0; i < 8; i++) begin
            WriteEn_in = 1'b1;
            Data_in    = 32'h100 + 32'(i);
            tick();
        end
        for (int i = 8; i < 48; i++) begin
            WriteEn_in = 1'b1;
            ReadEn_in  = 1'b1;
            Data_in    = 32'h100 + 32'(i);
            tick();
            total++;
            if (Valid_out !== 1'b1 || Data_out !== 32'h100 + 32'(exp_next) ||
                Level_out !== 5'd8 || ack_write !== 1'b1) begin
                bad++;
                $display("FAIL wrap cyc=%0d valid=%b data=%h lvl=%0d ack=%b exp 1 %h 8 1",
                         i, Valid_out, Data_out, Level_out, ack_write,
                         32'h100 + 32'(exp_next));
            end
            exp_next++;
        end
        WriteEn_in = 1'b0;
        ReadEn_in  = 1'b0;
        Flush_in   = 1'b1;
        tick();
        Flush_in   = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Level 1 with simultaneous read+write returns the old word.
        WriteEn_in = 1'b1;
        Data_in    = 32'h55;
        tick();
        ReadEn_in  = 1'b1;
        Data_in    = 32'h66;
        tick();
        WriteEn_in = 1'b0;
        total++;
        if (Valid_out !== 1'b1 || Data_out !== 32'h55 || Level_out !== 5'd1) begin
            bad++;
            $display("FAIL rw_level1 valid=%b data=%h lvl=%0d exp 1 00000055 1",
                     Valid_out, Data_out, Level_out);
        end
        tick();
        ReadEn_in = 1'b0;
        total++;
        if (Valid_out !== 1'b1 || Data_out !== 32'h66 || Empty_out !== 1'b1) begin
            bad++;
            $display("FAIL rw_level1_next valid=%b data=%h empty=%b exp 1 00000066 1",
                     Valid_out, Data_out, Empty_out);
        end
        // At full, simultaneous read+write: read only, overflow sets.
        fill16(32'h200, 1'b0);
        WriteEn_in = 1'b1;
        ReadEn_in  = 1'b1;
        Data_in    = 32'hDEAD;
        tick();
        WriteEn_in = 1'b0;
        ReadEn_in  = 1'b0;
        total++;
        if (ack_write !== 1'b0 || Valid_out !== 1'b1 || Data_out !== 32'h201 ||
            Level_out !== 5'd15 || Overflow_out !== 1'b1) begin
            bad++;
            $display("FAIL rw_full ack=%b valid=%b data=%h lvl=%0d ovf=%b exp 0 1 00000201 15 1",
                     ack_write, Valid_out, Data_out, Level_out, Overflow_out);
        end
        Flush_in = 1'b1;
        tick();
        Flush_in = 1'b0;
    endtask

    task automatic test_flush_write();
        for (int i = 0; i < 5; i++) begin
            WriteEn_in = 1'b1;
            Data_in    = 32'h300 + 32'(i);
            tick();
        end
        Flush_in = 1'b1;
        Data_in  = 32'h77;
        tick();
        Flush_in   = 1'b0;
        WriteEn_in = 1'b0;
        total++;
        if (ack_write !== 1'b0 || Level_out !== 5'd0 || Empty_out !== 1'b1 ||
            Overflow_out !== 1'b0) begin
            bad++;
            $display("FAIL flush_write ack=%b lvl=%0d empty=%b ovf=%b exp 0 0 1 0",
                     ack_write, Level_out, Empty_out, Overflow_out);
        end
        WriteEn_in = 1'b1;
        Data_in    = 32'hA5;
        tick();
        WriteEn_in = 1'b0;
        total++;
        if (ack_write !== 1'b1 || Level_out !== 5'd1) begin
            bad++;
            $display("FAIL post_flush_write ack=%b lvl=%0d exp 1 1", ack_write, Level_out);
        end
        ReadEn_in = 1'b1;
        tick();
        ReadEn_in = 1'b0;
        total++;
        if (Valid_out !== 1'b1 || Data_out !== 32'hA5) begin
            bad++;
            $display("FAIL post_flush_read valid=%b data=%h exp 1 000000a5", Valid_out, Data_out);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            WriteEn_in = 1'b1;
            Data_in    = 32'h400 + 32'(i);
            tick();
        end
        WriteEn_in = 1'b0;
        ReadEn_in  = 1'b1;
        tick();
        tick();
        total++;
        if (Data_out !== 32'h401 || Level_out !== 5'd4) begin
            bad++;
            $display("FAIL burst_before_reset data=%h lvl=%0d exp 00000401 4", Data_out, Level_out);
        end
        Reset = 1'b1;
        tick();
        Reset     = 1'b0;
        ReadEn_in = 1'b0;
        total++;
        if (status() !== 8'b0000_1100 || Level_out !== 5'd0 || Data_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid flags=%b lvl=%0d data=%h exp 00001100 0 00000000",
                     status(), Level_out, Data_out);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow_flush();
        test_wrap();
        test_back_to_back();
        test_flush_write();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dma_sync_fifo
`default_nettype wire
